// File: rtl/parabola_pkg.sv
// Shared constants for the parabola shift controller:
// UART command bytes, controller state enum, default width.
package parabola_pkg;

  localparam int H_ACTIVE_DEF = 800;

  localparam logic [7:0] CMD_START = 8'h53;
  localparam logic [7:0] CMD_PAUSE = 8'h50;
  localparam logic [7:0] CMD_STEP  = 8'h31;
  localparam logic [7:0] CMD_FAST  = 8'h2B;
  localparam logic [7:0] CMD_SLOW  = 8'h2D;
  localparam logic [7:0] CMD_REV   = 8'h52;
  localparam logic [7:0] CMD_CLR   = 8'h43;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    BURST
  } state_t;

endpackage

// File: rtl/parabola_shift_ctrl_burst.sv
// shift_burst_gen: BURST_LEN one-cycle pulses, each followed by GAP idle cycles.
// Ports: clk, rst_n, start (begin burst), en_shift (raw pulse), done (last gap cycle).
module shift_burst_gen #(
  parameter int BURST_LEN = 4,
  parameter int GAP       = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic en_shift,
  output logic done
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int PW = $clog2(GAP + 1);

  logic          active;
  logic [PW-1:0] ph;
  logic [CW-1:0] cnt;
  logic          last_ph;
  logic          last_pulse;

  assign last_ph    = (ph == PW'(GAP));
  assign last_pulse = (cnt == CW'(BURST_LEN - 1));
  assign en_shift   = active && (ph == '0);
  assign done       = active && last_ph && last_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      ph     <= '0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      ph     <= '0;
      cnt    <= '0;
    end else if (active) begin
      if (last_ph) begin
        ph  <= '0;
        cnt <= cnt + CW'(1);
        if (last_pulse)
          active <= 1'b0;
      end else begin
        ph <= ph + PW'(1);
      end
    end
  end

endmodule

// File: rtl/parabola_shift_ctrl.sv
// Horizontal-shift sequencer: UART commands in, frame-synced en_shift bursts out.
// Ports: pixel_clk, rst_n, frame_start, cmd_valid/data/ready, en_shift, shift_dir,
// shift_pos, rate, running. Macro POS_WRAP_EN: wrap shift_pos instead of saturating.
module parabola_shift_ctrl
  import parabola_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int DIV_W     = 6,
  parameter int RATE_RST  = 4,
  parameter int BURST_LEN = 4,
  parameter int GAP       = 1
) (
  input  logic                        pixel_clk,
  input  logic                        rst_n,
  input  logic                        frame_start,
  input  logic                        cmd_valid,
  input  logic [7:0]                  cmd_data,
  output logic                        cmd_ready,
  output logic                        en_shift,
  output logic                        shift_dir,
  output logic [$clog2(H_ACTIVE)-1:0] shift_pos,
  output logic [DIV_W-1:0]            rate,
  output logic                        running
);

  localparam int POS_W = $clog2(H_ACTIVE);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(H_ACTIVE - 1);

  state_t             state, state_n;
  state_t             saved, saved_n;
  logic [DIV_W-1:0]   fcnt, fcnt_n;
  logic [DIV_W-1:0]   rate_n;
  logic               dir_n;
  logic [POS_W-1:0]   pos_n;
  logic               armed, armed_n;
  logic               hit, hit_n;

  logic               accept;
  logic               cmd_sp;
  logic               trig;
  logic               pulse;
  logic               done;
  logic               at_edge;
  logic               blocked;
  logic [POS_W-1:0]   pos_step;

  assign cmd_ready = (state != BURST);
  assign accept    = cmd_valid && cmd_ready;
  // start/pause override a coincident triggering frame_start
  assign cmd_sp    = accept &&
                     (cmd_data == CMD_START || cmd_data == CMD_PAUSE);

  assign at_edge = shift_dir ? (shift_pos == '0)
                             : (shift_pos == POS_MAX);
  assign pos_step = shift_dir
    ? ((shift_pos == '0) ? POS_MAX : shift_pos - POS_W'(1))
    : ((shift_pos == POS_MAX) ? '0 : shift_pos + POS_W'(1));

`ifdef POS_WRAP_EN
  assign blocked = 1'b0;
`else
  assign blocked = at_edge;
`endif

  assign en_shift = pulse && !blocked;
  assign running  = (state == RUN) ||
                    (state == BURST && saved == RUN);

  shift_burst_gen #(
    .BURST_LEN(BURST_LEN),
    .GAP      (GAP)
  ) u_burst (
    .clk     (pixel_clk),
    .rst_n   (rst_n),
    .start   (trig),
    .en_shift(pulse),
    .done    (done)
  );

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      saved     <= IDLE;
      fcnt      <= '0;
      rate      <= DIV_W'(RATE_RST);
      shift_dir <= 1'b0;
      shift_pos <= '0;
      armed     <= 1'b0;
      hit       <= 1'b0;
    end else begin
      state     <= state_n;
      saved     <= saved_n;
      fcnt      <= fcnt_n;
      rate      <= rate_n;
      shift_dir <= dir_n;
      shift_pos <= pos_n;
      armed     <= armed_n;
      hit       <= hit_n;
    end
  end

  always_comb begin
    state_n = state;
    saved_n = saved;
    fcnt_n  = fcnt;
    rate_n  = rate;
    dir_n   = shift_dir;
    pos_n   = shift_pos;
    armed_n = armed;
    hit_n   = hit;
    trig    = 1'b0;

    if (accept) begin
      unique case (1'b1)
        cmd_data == CMD_START: begin
          state_n = RUN;
          fcnt_n  = '0;
          armed_n = 1'b0;
        end
        cmd_data == CMD_PAUSE: begin
          state_n = IDLE;
          armed_n = 1'b0;
        end
        cmd_data == CMD_STEP: begin
          if (state == IDLE)
            armed_n = 1'b1;
        end
        cmd_data == CMD_FAST: begin
          if (rate > DIV_W'(1))
            rate_n = rate - DIV_W'(1);
        end
        cmd_data == CMD_SLOW: begin
          if (rate != {DIV_W{1'b1}})
            rate_n = rate + DIV_W'(1);
        end
        cmd_data == CMD_REV: dir_n = ~shift_dir;
        cmd_data == CMD_CLR: pos_n = '0;
        default: ;
      endcase
    end

    unique case (state)
      IDLE: begin
        if (frame_start && armed && !cmd_sp) begin
          trig    = 1'b1;
          state_n = BURST;
          saved_n = IDLE;
          armed_n = 1'b0;
          hit_n   = 1'b0;
        end
      end
      RUN: begin
        if (frame_start && !cmd_sp) begin
          // >= so a rate lowered below the count still fires
          if (fcnt >= rate - DIV_W'(1)) begin
            trig    = 1'b1;
            fcnt_n  = '0;
            state_n = BURST;
            saved_n = RUN;
            hit_n   = 1'b0;
          end else begin
            fcnt_n = fcnt + DIV_W'(1);
          end
        end
      end
      BURST: begin
        if (en_shift)
          pos_n = pos_step;
        if (pulse && blocked)
          hit_n = 1'b1;
        if (done)
          state_n = hit ? IDLE : saved;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_parabola_shift_ctrl.sv
// Bench for parabola_shift_ctrl: directed steps, pulse scoreboard.
// Honours POS_WRAP_EN the same way as the design.
module tb_parabola_shift_ctrl;
  import parabola_pkg::*;

  localparam int H = 800;

  logic       pixel_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready;
  logic       en_shift;
  logic       shift_dir;
  logic [9:0] shift_pos;
  logic [5:0] rate;
  logic       running;

  parabola_shift_ctrl dut (
    .pixel_clk  (pixel_clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .cmd_valid  (cmd_valid),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready),
    .en_shift   (en_shift),
    .shift_dir  (shift_dir),
    .shift_pos  (shift_pos),
    .rate       (rate),
    .running    (running)
  );

  always #5 pixel_clk = ~pixel_clk;

  int cyc = 0;
  always @(posedge pixel_clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int p;
  } ev_t;
  ev_t sb[$];

  int nchk = 0;
  int nerr = 0;

  int mpos = 0;
  int mrate = 4;
  int mcnt = 0;
  bit mrun = 0;
  bit marmed = 0;
  bit mdir = 0;

  bit pend = 0;
  int pexp = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge pixel_clk) begin
    if (pend) begin
      chk("pos_after_pulse", 32'(shift_pos), 32'(pexp));
      pend = 0;
    end
    if (rst_n && en_shift !== 1'b0) begin
      chk("pulse_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        ev_t e;
        e = sb.pop_front();
        chk("pulse_cycle", cyc, e.c);
        pend = 1;
        pexp = e.p;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge pixel_clk);
  endtask

  function automatic int nextpos(int p, bit d);
    if (d) return (p == 0) ? H - 1 : p - 1;
    return (p == H - 1) ? 0 : p + 1;
  endfunction

  function automatic bit blk(int p, bit d);
`ifdef POS_WRAP_EN
    return 1'b0;
`else
    return d ? (p == 0) : (p == H - 1);
`endif
  endfunction

  task automatic model_burst(int fs);
    bit hit = 0;
    for (int k = 0; k < 4; k++) begin
      if (blk(mpos, mdir)) hit = 1;
      else begin
        mpos = nextpos(mpos, mdir);
        sb.push_back('{fs + 1 + 2 * k, mpos});
      end
    end
    if (hit) mrun = 0;
  endtask

  task automatic model_cmd(logic [7:0] b);
    case (b)
      CMD_START: begin mrun = 1; mcnt = 0; marmed = 0; end
      CMD_PAUSE: begin mrun = 0; marmed = 0; end
      CMD_STEP:  if (!mrun) marmed = 1;
      CMD_FAST:  if (mrate > 1) mrate--;
      CMD_SLOW:  if (mrate < 63) mrate++;
      CMD_REV:   mdir = !mdir;
      CMD_CLR:   mpos = 0;
      default: ;
    endcase
  endtask

  task automatic model_frame(int fs);
    bit go = 0;
    if (mrun) begin
      if (mcnt >= mrate - 1) begin mcnt = 0; go = 1; end
      else mcnt++;
    end else if (marmed) begin
      marmed = 0;
      go = 1;
    end
    if (go) model_burst(fs);
  endtask

  task automatic send(logic [7:0] b);
    cmd_valid = 1'b1;
    cmd_data = b;
    model_cmd(b);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic frame();
    int fs = cyc;
    frame_start = 1'b1;
    model_frame(fs);
    tick();
    frame_start = 1'b0;
    tick(10);
  endtask

  task automatic frame_cmd(logic [7:0] b);
    int fs = cyc;
    frame_start = 1'b1;
    cmd_valid = 1'b1;
    cmd_data = b;
    model_cmd(b);
    model_frame(fs);
    tick();
    frame_start = 1'b0;
    cmd_valid = 1'b0;
    tick(10);
  endtask

  task automatic frame_hold();
    int fs = cyc;
    frame_start = 1'b1;
    model_frame(fs);
    tick();
    frame_start = 1'b0;
    cmd_valid = 1'b1;
    cmd_data = CMD_SLOW;
    chk("running_in_burst", 32'(running), 1);
    for (int i = 0; i < 8; i++) begin
      chk("ready_low_in_burst", 32'(cmd_ready), 0);
      tick();
    end
    chk("ready_after_burst", 32'(cmd_ready), 1);
    chk("rate_before_accept", 32'(rate), 32'(mrate));
    model_cmd(CMD_SLOW);
    tick();
    cmd_valid = 1'b0;
    chk("rate_after_accept", 32'(rate), 32'(mrate));
    tick(2);
  endtask

  task automatic check_state(string tag);
    chk({tag, "_pos"}, 32'(shift_pos), 32'(mpos));
    chk({tag, "_rate"}, 32'(rate), 32'(mrate));
    chk({tag, "_dir"}, 32'(shift_dir), 32'(mdir));
    chk({tag, "_running"}, 32'(running), 32'(mrun));
  endtask

  initial begin
    int fs;
    tick(3);
    chk("rst_en_shift", 32'(en_shift), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    check_state("rst");
    rst_n = 1'b1;
    tick(2);

    send(CMD_START);
    repeat (8) frame();
    check_state("run8");
    chk("run8_pos_const", 32'(shift_pos), 8);

    send(CMD_PAUSE);
    chk("pause_running", 32'(running), 0);
    send(CMD_STEP);
    frame();
    check_state("step");
    frame();
    check_state("step_nofire");

    send(CMD_START);
    send(CMD_STEP);
    send(CMD_PAUSE);
    frame();
    check_state("step_in_run");

    repeat (5) send(CMD_FAST);
    chk("rate_min", 32'(rate), 1);
    send(CMD_FAST);
    chk("rate_min_sat", 32'(rate), 1);
    send(CMD_START);
    repeat (2) frame();
    check_state("rate1");
    repeat (70) send(CMD_SLOW);
    chk("rate_max", 32'(rate), 63);
    repeat (59) send(CMD_FAST);
    chk("rate_back", 32'(rate), 4);

    repeat (3) frame();
    frame_hold();
    check_state("hold");
    send(CMD_FAST);

    send(CMD_START);
    repeat (3) frame();
    frame_cmd(CMD_PAUSE);
    check_state("pause_coinc");

    send(CMD_CLR);
    send(CMD_REV);
    chk("rev_dir", 32'(shift_dir), 1);
    send(CMD_START);
    repeat (4) frame();
    check_state("left_edge");

    send(CMD_PAUSE);
    send(CMD_CLR);
    send(CMD_REV);
    repeat (3) send(CMD_FAST);
    send(CMD_START);
    repeat (200) frame();
    check_state("right_edge");

    send(CMD_PAUSE);
    send(CMD_CLR);
    send(CMD_STEP);
    fs = cyc;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    marmed = 0;
    mpos = nextpos(mpos, mdir);
    sb.push_back('{fs + 1, mpos});
    tick();
    @(posedge pixel_clk);
    #1;
    chk("abort_pulse2_live", 32'(en_shift), 1);
    rst_n = 1'b0;
    #1;
    mpos = 0; mrate = 4; mdir = 0;
    mrun = 0; mcnt = 0; marmed = 0;
    chk("abort_en_shift", 32'(en_shift), 0);
    chk("abort_cmd_ready", 32'(cmd_ready), 1);
    check_state("abort");
    tick();
    rst_n = 1'b1;
    tick(12);
    check_state("abort_after");

    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/parabola_shift_ctrl.md
Name: parabola_shift_ctrl

Overview:
Sequencer for the parabola generator's horizontal shift. It decodes single-byte UART commands (start, pause, step, speed, reverse, clear) and issues frame-synchronous bursts of one-cycle en_shift pulses on pixel_clk. It also tracks the resulting shift position. It sits between the UART RX byte stream and Gen_parabola, in the pixel clock domain; bytes arrive already synchronised.

Parameters:
H_ACTIVE, 800, visible width; shift_pos range is 0..H_ACTIVE-1
DIV_W, 6, width of the frame-divider rate register
RATE_RST, 4, reset frames-per-event value (1..2^DIV_W-1)
BURST_LEN, 4, en_shift pulses per shift event
GAP, 1, idle cycles between pulses within a burst (>=1)

Ports:
pixel_clk  in  1  pixel clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse at the start of vertical blanking
cmd_valid  in  1  command byte valid
cmd_data  in  8  command byte (ASCII)
cmd_ready  out  1  controller accepts a byte this cycle
en_shift  out  1  one-cycle shift enable to the generator
shift_dir  out  1  0 = right (+1 per pulse), 1 = left (-1)
shift_pos  out  $clog2(H_ACTIVE)  current shift position
rate  out  DIV_W  frames per shift event
running  out  1  high in RUN and in a BURST started from RUN

Behaviour:
- Reset values: en_shift=0, shift_dir=0, shift_pos=0, rate=RATE_RST, running=0, cmd_ready=1, state=IDLE, frame counter=0.
- Handshake: a byte is consumed when cmd_valid&&cmd_ready. cmd_ready=0 only in BURST. Unknown bytes are consumed and ignored.
- Commands:
  - 'S'(0x53): go to RUN; clear frame counter.
  - 'P'(0x50): go to IDLE.
  - '1'(0x31): arm a single event; valid in IDLE only, ignored in RUN.
  - '+'(0x2B): rate-1, saturating at 1.
  - '-'(0x2D): rate+1, saturating at 2^DIV_W-1.
  - 'R'(0x52): toggle shift_dir.
  - 'C'(0x43): shift_pos=0.
- States:
  - IDLE: if a step is armed, go to BURST at the next frame_start, then return to IDLE.
  - RUN: count frame_start pulses. When count==rate-1 and frame_start, clear the count and go to BURST, then return to RUN.
  - BURST: emit BURST_LEN pulses. Each pulse is high 1 cycle, then low for GAP cycles. The first pulse is in the cycle after the triggering frame_start. Each pulse updates shift_pos by ±1 in the same cycle. After the last pulse plus its GAP, return to the saved state.
- frame_start during BURST is ignored; no queuing.
- 'P' received in the same cycle as a frame_start that would trigger a burst: the command wins and no burst occurs.
- shift_pos boundaries depend on the optional feature below.
- Asserting rst_n mid-burst aborts it immediately, with no further pulses.

Optional Feature:
POS_WRAP_EN
- Defined: shift_pos wraps modulo H_ACTIVE in both directions (H_ACTIVE-1 → 0 going right, 0 → H_ACTIVE-1 going left).
- Undefined: shift_pos saturates at the boundary. A pulse that would move past the boundary is suppressed (en_shift stays 0). The burst still completes its timing, then the state is forced to IDLE (running=0).

Decomposition:
- Shared package parabola_pkg: command byte constants (CMD_START, CMD_PAUSE, CMD_STEP, CMD_FAST, CMD_SLOW, CMD_REV, CMD_CLR), state enum {IDLE, RUN, BURST}, H_ACTIVE default.
- One sub-module: shift_burst_gen (pulse/gap counter, start in, done out, en_shift out).

Test Plan:
- Reset then 'S', rate=4, BURST_LEN=4, GAP=1 → after every 4th frame_start, en_shift pulses in cycles +1, +3, +5, +7. shift_pos goes 0 → 4 → 8.
- In IDLE, '1' then one frame_start → exactly 4 pulses, shift_pos=4, state stays IDLE, running=0. '1' sent while in RUN → no extra burst.
- '+' five times from rate=4 → rate=1 (saturated), one burst per frame. '-' 70 times → rate=63.
- 'R' at shift_pos=2, then a burst → shift_pos goes 2 → 0 on the first 2 pulses, then:
  - POS_WRAP_EN defined: 799, 798.
  - POS_WRAP_EN undefined: 2 pulses suppressed, state ends in IDLE.
- cmd_valid held during BURST → cmd_ready=0 throughout, byte accepted in the first cycle after the burst. 'P' coincident with a triggering frame_start → no pulses, state IDLE.
- rst_n low during the 2nd pulse of a burst → en_shift=0 immediately, shift_pos=0, state IDLE, rate=RATE_RST.
